// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and helpers for the bit-serial subtractor.
//               Holds the FSM state type, the default operand width and the
//               bit-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int WIDTH_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit-counter width: enough to hold WIDTH-1, never narrower than one bit
    function automatic int cnt_width(input int w);
        int r;
        r = $clog2(w);
        return (r < 1) ? 1 : r;
    endfunction

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/serial_subtractor_fs_bit.sv
`default_nettype none
// ============================================================================
// Module      : fs_bit
// Description : Combinational one-bit full subtractor.
//               d = a ^ b ^ bin, bout = borrow generated by a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module fs_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // A borrow is generated when b exceeds a, or propagated when a == b
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : fs_bit
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial WIDTH-bit full subtractor, d = a - b - bin,
//               processed LSB first, one bit per clock. Operands are
//               captured on an accepted start; d/bout are registered on
//               completion and held until the next completion.
//               Optional feature macro: SERIAL_SUB_OVF_EN adds the signed
//               overflow output ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             state_q,  state_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   res_q,    res_d;
    logic [WIDTH-1:0]   d_q,      d_d;
    logic               bout_q,   bout_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are kept aside because the shift registers consume them
    logic               a_msb_q,  a_msb_d;
    logic               b_msb_q,  b_msb_d;
    logic               ovf_q,    ovf_d;
`endif

    logic               bit_diff;
    logic               bit_borrow;
    logic [WIDTH-1:0]   res_next;
    logic               accept;

    // Single shared bit slice operating on the current operand LSBs
    fs_bit u_fs_bit (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (bit_diff),
        .bout (bit_borrow)
    );

    // The new difference bit enters at the MSB so the LSB lands at bit 0 last
    generate
        if (WIDTH > 1) begin : g_res_wide
            assign res_next = {bit_diff, res_q[WIDTH-1:1]};
        end else begin : g_res_one
            assign res_next = bit_diff;
        end
    endgenerate

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        d_d      = d_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = bit_borrow;
                res_d    = res_next;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    d_d     = res_next;
                    bout_d  = bit_borrow;
`ifdef SERIAL_SUB_OVF_EN
                    // Final difference bit is the result MSB
                    ovf_d   = (a_msb_q != b_msb_q) && (bit_diff != a_msb_q);
`endif
                end
            end
            ST_DONE: begin
                state_d = start ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture a fresh operand set whenever a request is accepted
        if (accept) begin
            a_sh_d   = a;
            b_sh_d   = b;
            borrow_d = bin;
            cnt_d    = '0;
            res_d    = '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_d  = a[WIDTH-1];
            b_msb_d  = b[WIDTH-1];
`endif
        end

        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; async reset clears everything incl. results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=3).
//               Optional feature macro: SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] a;
    logic [2:0] b;
    logic       bin;
    wire        busy;
    wire        done;
    wire  [2:0] d;
    wire        bout;
`ifdef SERIAL_SUB_OVF_EN
    wire        ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One isolated operation: start pulsed for one cycle, then latency/result checks
    task automatic run_op(input string tag, input logic [2:0] ia, input logic [2:0] ib,
                          input logic ibin, input logic [2:0] ed, input logic eb,
                          input logic eovf);
        @(negedge clk);
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ia; b = ~ib; bin = ~ibin;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_nodone"}, done, 0);
        end
        @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_d"}, d, ed);
        check({tag, "_bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, ovf, eovf);
`else
        if (eovf === 1'bx) $display("unused ovf expectation");
`endif
        @(negedge clk);
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_d_hold"}, d, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] kv;
        logic [2:0] ea, eb_op;
        logic       ebin;
        logic [3:0] full;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", d, 0);
        check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-computed results
        run_op("t1_5m3",    3'd5, 3'd3, 1'b0, 3'd2, 1'b0, 1'b1);
        run_op("t2_3m5",    3'd3, 3'd5, 1'b0, 3'd6, 1'b1, 1'b1);
        run_op("t2_0m0b1",  3'd0, 3'd0, 1'b1, 3'd7, 1'b1, 1'b0);
        run_op("t6_3m4",    3'd3, 3'd4, 1'b0, 3'd7, 1'b1, 1'b1);
        run_op("t6_2m1",    3'd2, 3'd1, 1'b0, 3'd1, 1'b0, 1'b0);

        // Exhaustive back-to-back with start held high: one result every 4 cycles
        @(negedge clk);
        a = 3'd0; b = 3'd0; bin = 1'b0; start = 1'b1;
        for (int k = 0; k < 128; k++) begin
            kv    = k[6:0];
            ea    = kv[6:4];
            eb_op = kv[3:1];
            ebin  = kv[0];
            @(posedge clk);
            #1;
            if (k < 127) begin
                kv  = 7'(k + 1);
                a   = kv[6:4];
                b   = kv[3:1];
                bin = kv[0];
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check("t3_accept_busy", busy, 1);
            check("t3_accept_nodone", done, 0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            full = {1'b0, ea} - {1'b0, eb_op} - {3'b000, ebin};
            check("t3_done", done, 1);
            check("t3_d", d, full[2:0]);
            check("t3_bout", bout, ({1'b0, ea} < ({1'b0, eb_op} + {3'b000, ebin})));
`ifdef SERIAL_SUB_OVF_EN
            check("t3_ovf", ovf, (ea[2] != eb_op[2]) && (full[2] != ea[2]));
`endif
        end
        @(negedge clk);
        check("t3_end_nodone", done, 0);
        check("t3_end_idle", busy, 0);

        // Start while busy is ignored: 1-2 completes, 6-1 never runs
        @(negedge clk);
        a = 3'd1; b = 3'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1; a = 3'd6; b = 3'd1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("t4_busy", busy, 1);
        check("t4_nodone", done, 0);
        @(negedge clk);
        check("t4_done", done, 1);
        check("t4_d", d, 3'd7);
        check("t4_bout", bout, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
        check("t4_ovf", ovf, 1'b0);
`endif
        @(negedge clk);
        check("t4_done_drop", done, 0);
        @(negedge clk);
        check("t4_no_rerun_busy", busy, 0);
        check("t4_no_rerun_done", done, 0);

        // Reset during the second SHIFT cycle
        @(negedge clk);
        a = 3'd5; b = 3'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_d", d, 0);
        check("t5_rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("t5_rst_ovf", ovf, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_no_done", done, 0);
        end
        run_op("t5_after", 3'd5, 3'd3, 1'b0, 3'd2, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
